// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared types and constants for the PQC math datapath
package math_pkg;

  localparam int MATH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring division iteration
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // The compare uses the full shifted value so no bit of R is silently dropped.
  always_comb begin
    shifted = {r_i, q_msb_i};
    diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
    q_bit_o = (shifted >= {2'b00, divisor_i});
    r_o     = q_bit_o ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring unsigned divider, 2*WIDTH by WIDTH
module seq_divider
  import math_pkg::*;
#(
  parameter int WIDTH = MATH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

  div_state_e       state_q;
  logic [WIDTH:0]   r_q;
  logic [QW-1:0]    q_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [QW-1:0]    quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;

  logic [WIDTH:0]   r_d;
  logic             q_bit_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[QW-1]),
    .divisor_i (div_q),
    .r_o       (r_d),
    .q_bit_o   (q_bit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            q_q        <= dividend;
            div_q      <= divisor;
            r_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          r_q   <= r_d;
          q_q   <= {q_q[QW-2:0], q_bit_d};
          cnt_q <= cnt_q + CW'(1);
          // Results are captured straight from the last step so out_valid
          // rises on the same edge as the final iteration.
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            quot_q      <= {q_q[QW-2:0], q_bit_d};
            rem_q       <= r_d[WIDTH-1:0];
            dz_q        <= (div_q == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] dvd, input logic [7:0] dvs);
    int n;
    n = 0;
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 8) check("busy_in_ready", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 100);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    accept(dvd, dvs);
    wait_result(lat);
    check("latency", 32'(lat), 32'd16);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    handshake();
  endtask

  initial begin
    int lat;
    int spurious;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    #1 check("pre_edge_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    do_op(16'h0006, 8'h03, 16'h0002, 8'h00, 1'b0);
    do_op(16'h3A24, 8'h3D, 16'h00F4, 8'h00, 1'b0);
    do_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
    do_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);

    // Backpressure, with a second operation offered the whole time.
    accept(16'h3A27, 8'h3D);
    dividend = 16'h0157;
    divisor  = 8'h04;
    in_valid = 1'b1;
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd16);
    for (int i = 0; i < 5; i++) begin
      check("bp_quotient", 32'(quotient), 32'h00F4);
      check("bp_remainder", 32'(remainder), 32'h03);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_hold_quotient", 32'(quotient), 32'h00F4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_out_valid", 32'(out_valid), 32'd0);
    check("bp_hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("second_latency", 32'(lat), 32'd16);
    check("second_quotient", 32'(quotient), 32'h0055);
    check("second_remainder", 32'(remainder), 32'h03);
    handshake();

    // Reset in the middle of BUSY.
    accept(16'h1234, 8'h3D);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("midrst_spurious", 32'(spurious), 32'd0);
    check("midrst_idle_ready", 32'(in_ready), 32'd1);
    do_op(16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
